pinball_game_ctrl: RTL

- Top-level game sequencer for the pinball table.
- Generates the 3-bit game state consumed by the ball sensor block and the display logic.
- Times the post-hit GET display window and accumulates score from the hole the ball landed in.
- Sits between the debounced buttons, the raw hole sensors, and the ball-count/hole-capture block.

---
 rtl/pinball_game_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pinball_game_ctrl.sv
// Pinball table game sequencer: game FSM, GET display timer and saturating score.
// Define PINBALL_HISCORE_EN to add the high_score / new_record outputs.
module pinball_game_ctrl #(
  parameter int GET_CYCLES = 100000000,
  parameter int PTS_UNIT   = 10,
  parameter int SCORE_MAX  = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_reset,
  input  logic [7:0]  ball,
  input  logic [7:0]  getball,
  input  logic [3:0]  ball_num,
  output logic [2:0]  state,
  output logic [13:0] score,
  output logic        hit_pulse,
  output logic        game_over
`ifdef PINBALL_HISCORE_EN
  ,
  output logic [13:0] high_score,
  output logic        new_record
`endif
);

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_GET   = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int TW = $clog2(GET_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(GET_CYCLES - 1);
  localparam logic [14:0] SCORE_CAP = 15'(SCORE_MAX);

  state_t         cur;
  logic [TW-1:0]  timer;
  logic [14:0]    hole_pts;
  logic [14:0]    score_sum;
  logic [13:0]    score_sat;

  // getball is produced on the same edge as the hit, so scoring relies on ball.
  logic unused_getball;
  assign unused_getball = ^getball;

  assign state = cur;

  // Walk downward so the lowest set hole index ends up winning.
  always_comb begin
    hole_pts = '0;
    for (int i = 7; i >= 0; i--) begin
      if (ball[i]) hole_pts = 15'((i + 1) * PTS_UNIT);
    end
    score_sum = {1'b0, score} + hole_pts;
    score_sat = (score_sum > SCORE_CAP) ? SCORE_CAP[13:0] : score_sum[13:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= S_RESET;
      score     <= '0;
      timer     <= '0;
      hit_pulse <= 1'b0;
      game_over <= 1'b0;
`ifdef PINBALL_HISCORE_EN
      high_score <= '0;
      new_record <= 1'b0;
`endif
    end else begin
      hit_pulse <= 1'b0;
      game_over <= 1'b0;
`ifdef PINBALL_HISCORE_EN
      new_record <= 1'b0;
`endif
      if (btn_reset) begin
        cur <= S_RESET;
      end else begin
        case (cur)
          S_RESET: begin
            score <= '0;
            timer <= '0;
            cur   <= S_WAIT;
          end
          S_WAIT: begin
            if (btn_start) cur <= S_START;
          end
          S_START: begin
            if (ball != 8'd0) begin
              cur       <= S_GET;
              hit_pulse <= 1'b1;
              timer     <= '0;
              score     <= score_sat;
            end
          end
          S_GET: begin
            // A ball still resting in its hole holds GET so it is not scored twice.
            if (timer != TIMER_LAST) begin
              timer <= timer + TW'(1);
            end else if (ball_num == 4'd0) begin
              cur       <= S_OVER;
              game_over <= 1'b1;
`ifdef PINBALL_HISCORE_EN
              if (score > high_score) begin
                high_score <= score;
                new_record <= 1'b1;
              end
`endif
            end else if (ball == 8'd0) begin
              cur <= S_START;
            end
          end
          S_OVER: begin
            if (btn_start) cur <= S_RESET;
            else           game_over <= 1'b1;
          end
          default: cur <= S_RESET;
        endcase
      end
    end
  end

endmodule
